pipe_delay: RTL and testbench
=============================

PIPE_DELAY -- requirements
Module: pipe_delay

Interface
REQ-001 SHALL have parameter WIDTH, default 10, data bit width (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, number of register stages (>=1).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port flush  input  1  discard all held items.
REQ-006 SHALL have port in_valid  input  1  producer offers in_data.
REQ-007 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-008 SHALL have port in_data  input  WIDTH  input word.
REQ-009 SHALL have port out_valid  output  1  out_data holds a valid item.
REQ-010 SHALL have port out_ready  input  1  consumer takes out_data this cycle.
REQ-011 SHALL have port out_data  output  WIDTH  output word, driven from the last stage register.
REQ-012 SHALL have port count  output  CW = clog2(DEPTH+1)  number of valid stages.

Function
REQ-013 SHALL implement DEPTH stages S0..S(DEPTH-1), each holding a valid bit and a WIDTH data register; out_valid/out_data SHALL equal the valid bit and data of the last stage.
REQ-014 SHALL treat a transfer as occurring on an edge where valid and ready are both high; in_data is accepted only on in_valid && in_ready.
REQ-015 SHALL compute, per stage k, move_k = valid_k && (k is the last stage ? out_ready : (!valid_(k+1) || move_(k+1))).
REQ-016 SHALL compute in_ready = !flush && (!valid_0 || move_0); bubbles collapse and no stage is overwritten while valid and not moving.
REQ-017 SHALL, on a cycle with no backpressure and an empty pipe, present an accepted word at out_data exactly DEPTH cycles after acceptance (latency DEPTH).
REQ-018 SHALL sustain one transfer per cycle when out_ready is held high.
REQ-019 SHALL hold out_data and out_valid stable while out_valid && !out_ready.
REQ-020 SHALL preserve order and value: output sequence equals accepted input sequence, bit-exact, no loss, no duplication.
REQ-021 SHALL update count each cycle as count + (in accepted) - (out taken); range 0..DEPTH; count == DEPTH implies in_ready == 0 unless the last stage is moving.
REQ-022 SHALL, on flush high, clear all valid bits and count at the next edge, accept no input that cycle (in_ready low), and leave data registers unspecified; an out transfer in that cycle still counts as taken by the consumer.
REQ-023 SHALL hold state unchanged when in_valid low and out_ready low.
REQ-024 SHALL permit a combinational ready path from out_ready to in_ready through all stages; no other combinational input-to-output paths.

Reset
REQ-025 SHALL, when rst is high at an edge, clear all valid bits and count to 0; out_valid = 0 and in_ready = 1 the following cycle.
REQ-026 SHALL give rst priority over flush and over any in-flight transfer, mid-operation included.
REQ-027 SHALL leave data registers unreset; out_data is don't-care while out_valid is 0.

Structure
REQ-028 SHALL place the count-width function clog2 and the default WIDTH/DEPTH constants in shared package pipe_pkg.
REQ-029 SHALL build each stage from sub-module pipe_stage (ports clk, rst, flush, load, d, valid_q, q), instantiated DEPTH times via generate.

Verification (WIDTH=10, DEPTH=4)
REQ-030 SHALL check streaming: after rst, in_valid=1 with data 1,2,3,... and out_ready=1 -> out_valid rises 4 cycles after the first accept; outputs 1,2,3,... one per cycle; count steady at 4.
REQ-031 SHALL check backpressure: out_ready=0 while sending 5 words -> first 4 accepted, in_ready=0 on the 5th, count=4, out_data=1 held; then out_ready=1 -> 1,2,3,4,5 in order.
REQ-032 SHALL check bubble collapse: single word 10'h155, out_ready=0 -> word reaches S3 after 4 cycles; a second word 10'h2AA fills S2 without overwriting S3.
REQ-033 SHALL check flush: 3 words in flight, flush=1 for one cycle -> next cycle out_valid=0, count=0, the word offered during the flush cycle not accepted.
REQ-034 SHALL check reset mid-operation: rst=1 with count=4 and in_valid=1 -> next cycle count=0, out_valid=0, in_ready=1; no pre-reset word appears later.
REQ-035 SHALL check wrap values: data 10'h3FF then 10'h000 pass unchanged; a random stall scoreboard over 1000 cycles shows zero mismatches.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipe_delay register pipeline.
package pipe_pkg;

  localparam int DEFAULT_WIDTH = 10;
  localparam int DEFAULT_DEPTH = 4;

  // Ceiling log2, never smaller than 1 so that a count port always has a bit.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    if (result == 0) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline stage: a valid flag plus an unreset data register.
// The incoming word arrives packed as d = {valid, data}; when load is high the
// stage takes both, otherwise it holds. The caller raises load whenever the
// stage is empty or its current item is leaving, so an empty slot is refilled
// with whatever (possibly invalid) item sits upstream.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load,
  input  logic [WIDTH:0]   d,
  output logic             valid_q,
  output logic [WIDTH-1:0] q
);

  // Valid flag: reset and flush empty the stage, load takes the upstream flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= d[WIDTH];
    end
  end

  // Data register is deliberately left out of reset; it only matters when valid.
  always_ff @(posedge clk) begin
    if (load) begin
      q <= d[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/pipe_delay.sv
// Elastic delay line of DEPTH stages with valid/ready handshakes on both ends.
// Items advance whenever the stage ahead is free or itself advancing, so
// bubbles collapse and a full pipe streams one item per cycle.
module pipe_delay
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = clog2(DEPTH + 1);

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] move;
  logic [DEPTH-1:0] load;
  logic [WIDTH-1:0] data [DEPTH];
  logic             in_fire;
  logic             out_fire;

  // A stage moves when it holds an item and either the consumer takes it (last
  // stage) or some stage further downstream has a gap, or the last one drains.
  // Written in this flattened form so the ready chain has no loop through move.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [WIDTH:0] stage_d;

    if (k == DEPTH - 1) begin : g_last
      assign move[k] = valid[k] && out_ready;
    end else begin : g_inner
      assign move[k] = valid[k] && (out_ready || !(&valid[DEPTH-1:k+1]));
    end

    assign load[k] = !valid[k] || move[k];

    if (k == 0) begin : g_head
      assign stage_d = {in_fire, in_data};
    end else begin : g_body
      assign stage_d = {move[k-1], data[k-1]};
    end

    pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .load    (load[k]),
      .d       (stage_d),
      .valid_q (valid[k]),
      .q       (data[k])
    );
  end

  assign in_ready  = !flush && load[0];
  assign in_fire   = in_valid && in_ready;
  assign out_valid = valid[DEPTH-1];
  assign out_data  = data[DEPTH-1];
  assign out_fire  = move[DEPTH-1];

  // Occupancy tracks accepted minus taken items; reset and flush empty it.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      count <= count + CW'(in_fire) - CW'(out_fire);
    end
  end

endmodule

// File: tb/tb_pipe_delay.sv
// Self-checking bench for pipe_delay (WIDTH=10, DEPTH=4): directed scenarios
// followed by a randomized stall/flush run against a queue-based model.
module tb_pipe_delay;
  import pipe_pkg::*;

  localparam int WIDTH = 10;
  localparam int DEPTH = 4;
  localparam int CW    = clog2(DEPTH + 1);

  logic             clk;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;

  int n_cmp;
  int n_fail;
  int cyc;

  // Model item: the word and the earliest cycle it can be presented at the output.
  typedef struct {
    logic [WIDTH-1:0] data;
    int               t;
  } item_t;

  item_t wq[$];

  pipe_delay #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output is valid once the head item has had DEPTH cycles of travel and the
  // item ahead of it has left.
  function automatic bit m_out_valid();
    return (wq.size() > 0) && (wq[0].t <= cyc);
  endfunction

  function automatic logic [WIDTH-1:0] m_out_data();
    if (wq.size() > 0) return wq[0].data;
    return '0;
  endfunction

  // Room exists unless every stage is occupied and the consumer is not draining.
  function automatic bit m_in_ready();
    return !flush && ((wq.size() < DEPTH) || out_ready);
  endfunction

  function automatic void model_edge();
    bit    acc;
    bit    taken;
    item_t it;
    if (rst) begin
      wq.delete();
    end else begin
      acc   = in_valid && m_in_ready();
      taken = m_out_valid() && out_ready;
      if (taken) begin
        void'(wq.pop_front());
        if (wq.size() > 0 && wq[0].t < cyc + 1) wq[0].t = cyc + 1;
      end
      if (flush) begin
        wq.delete();
      end else if (acc) begin
        it.data = in_data;
        it.t    = cyc + DEPTH;
        wq.push_back(it);
      end
    end
    cyc++;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data  = '0;
  endtask

  task automatic drain();
    idle_inputs();
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) tick();
    out_ready = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (count !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset.count got=%0d want=0", count);
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset.out_valid got=%b want=0", out_valid);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset.in_ready got=%b want=1", in_ready);
    end
  endtask

  task automatic test_streaming();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      in_data = WIDTH'(i);
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL stream.in_ready i=%0d got=%b want=1", i, in_ready);
      end
      tick();
      n_cmp++;
      if (out_valid !== (i >= 4)) begin
        n_fail++;
        $display("[TB] FAIL stream.out_valid i=%0d got=%b want=%b", i, out_valid, (i >= 4));
      end
      if (i >= 4) begin
        n_cmp++;
        if (out_data !== WIDTH'(i - 3)) begin
          n_fail++;
          $display("[TB] FAIL stream.out_data i=%0d got=%0d want=%0d", i, out_data, i - 3);
        end
      end
      n_cmp++;
      if (count !== CW'(i < 4 ? i : 4)) begin
        n_fail++;
        $display("[TB] FAIL stream.count i=%0d got=%0d want=%0d", i, count, (i < 4 ? i : 4));
      end
    end
    drain();
    n_cmp++;
    if (count !== '0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL stream.drained count=%0d out_valid=%b want 0/0", count, out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      in_data = WIDTH'(j);
      #1;
      n_cmp++;
      if (in_ready !== (j <= 4)) begin
        n_fail++;
        $display("[TB] FAIL bp.in_ready j=%0d got=%b want=%b", j, in_ready, (j <= 4));
      end
      tick();
    end
    n_cmp++;
    if (count !== CW'(4) || out_valid !== 1'b1 || out_data !== WIDTH'(1)) begin
      n_fail++;
      $display("[TB] FAIL bp.full count=%0d out_valid=%b out_data=%0d want 4/1/1", count, out_valid, out_data);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== WIDTH'(1) || count !== CW'(4)) begin
      n_fail++;
      $display("[TB] FAIL bp.hold out_valid=%b out_data=%0d count=%0d want 1/1/4", out_valid, out_data, count);
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL bp.ready_through got=%b want=1", in_ready);
    end
    for (int k = 1; k <= 5; k++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== WIDTH'(k)) begin
        n_fail++;
        $display("[TB] FAIL bp.order k=%0d out_valid=%b out_data=%0d want 1/%0d", k, out_valid, out_data, k);
      end
      tick();
      in_valid = 1'b0;
    end
    n_cmp++;
    if (out_valid !== 1'b0 || count !== '0) begin
      n_fail++;
      $display("[TB] FAIL bp.empty out_valid=%b count=%0d want 0/0", out_valid, count);
    end
    idle_inputs();
  endtask

  task automatic test_bubble();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 10'h155;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL bubble.early got=%b want=0", out_valid);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 10'h155 || count !== CW'(1)) begin
      n_fail++;
      $display("[TB] FAIL bubble.arrive out_valid=%b out_data=%h count=%0d want 1/155/1", out_valid, out_data, count);
    end
    in_valid = 1'b1;
    in_data  = 10'h2AA;
    tick();
    in_valid = 1'b0;
    in_data  = '0;
    tick();
    tick();
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 10'h155 || count !== CW'(2)) begin
      n_fail++;
      $display("[TB] FAIL bubble.no_overwrite out_valid=%b out_data=%h count=%0d want 1/155/2", out_valid, out_data, count);
    end
    out_ready = 1'b1;
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 10'h2AA) begin
      n_fail++;
      $display("[TB] FAIL bubble.second out_valid=%b out_data=%h want 1/2aa", out_valid, out_data);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL bubble.empty got=%b want=0", out_valid);
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int j = 0; j < 3; j++) begin
      in_data = WIDTH'(8'h11 * (j + 1));
      tick();
    end
    flush   = 1'b1;
    in_data = 10'h044;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL flush.in_ready got=%b want=0", in_ready);
    end
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || count !== '0) begin
      n_fail++;
      $display("[TB] FAIL flush.cleared out_valid=%b count=%0d want 0/0", out_valid, count);
    end
    out_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL flush.leak j=%0d out_valid=%b out_data=%h want 0", j, out_valid, out_data);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      in_data = WIDTH'(10'h100 + j);
      tick();
    end
    n_cmp++;
    if (count !== CW'(4)) begin
      n_fail++;
      $display("[TB] FAIL rstmid.full got=%0d want=4", count);
    end
    rst     = 1'b1;
    flush   = 1'b1;
    in_data = 10'h105;
    tick();
    rst      = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    n_cmp++;
    if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL rstmid.state count=%0d out_valid=%b in_ready=%b want 0/0/1", count, out_valid, in_ready);
    end
    out_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL rstmid.leak j=%0d out_data=%h want no output", j, out_data);
      end
    end
    idle_inputs();
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 10'h3FF;
    tick();
    in_data = 10'h000;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 10'h3FF) begin
      n_fail++;
      $display("[TB] FAIL wrap.ones out_valid=%b out_data=%h want 1/3ff", out_valid, out_data);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 10'h000) begin
      n_fail++;
      $display("[TB] FAIL wrap.zeros out_valid=%b out_data=%h want 1/000", out_valid, out_data);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      in_data   = WIDTH'($urandom);
      #1;
      n_cmp++;
      if (in_ready !== m_in_ready()) begin
        n_fail++;
        bad++;
        if (bad < 10) $display("[TB] FAIL rand.in_ready cyc=%0d got=%b want=%b", cyc, in_ready, m_in_ready());
      end
      n_cmp++;
      if (out_valid !== m_out_valid()) begin
        n_fail++;
        bad++;
        if (bad < 10) $display("[TB] FAIL rand.out_valid cyc=%0d got=%b want=%b", cyc, out_valid, m_out_valid());
      end
      n_cmp++;
      if (count !== CW'(wq.size())) begin
        n_fail++;
        bad++;
        if (bad < 10) $display("[TB] FAIL rand.count cyc=%0d got=%0d want=%0d", cyc, count, wq.size());
      end
      if (m_out_valid()) begin
        n_cmp++;
        if (out_data !== m_out_data()) begin
          n_fail++;
          bad++;
          if (bad < 10) $display("[TB] FAIL rand.out_data cyc=%0d got=%h want=%h", cyc, out_data, m_out_data());
        end
      end
      tick();
    end
    drain();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    cyc    = 0;
    rst    = 1'b1;
    idle_inputs();
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_flush();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
